// File: rtl/qsys_system_rom_pkg.sv
// Shared constants and types for the boot-ROM arbiter slice.
package qsys_system_rom_pkg;

    localparam int ROM_DEPTH = 2560;
    localparam int ROM_AW    = 12;
    localparam int ROM_DW    = 32;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_DATA   = 1'b1
    } port_e;

    localparam int ERR_RANGE = 0;
    localparam int ERR_NODBG = 1;

    typedef struct packed {
        logic  vld;
        port_e port;
        logic  oor;
    } rsp_t;

endpackage

// File: rtl/qsys_system_rom_arbiter_rr.sv
// Two-requester round-robin arbiter; the pointer names the port favoured on contention.
module rr_arbiter2
    import qsys_system_rom_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       hold,
    output logic [1:0] gnt
);

    port_e ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        if (!hold) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr_q == PORT_DATA) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After any grant the other port becomes the favoured one.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (gnt != 2'b00)) begin
            ptr_d = gnt[0] ? PORT_DATA : PORT_IFETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PORT_IFETCH;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/qsys_system_rom_arbiter.sv
// Shares the single-port boot ROM between the instruction master (port 0)
// and the data/debug master (port 1) with 1-cycle read latency.
module qsys_system_rom_arbiter
    import qsys_system_rom_pkg::*;
#(
    parameter int DEPTH = ROM_DEPTH,
    parameter int AW    = ROM_AW,
    parameter int DW    = ROM_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reset_req,
    input  logic [AW-1:0]   s0_address,
    input  logic            s0_read,
    output logic            s0_waitrequest,
    output logic [DW-1:0]   s0_readdata,
    output logic            s0_readdatavalid,
    input  logic [AW-1:0]   s1_address,
    input  logic            s1_read,
    input  logic            s1_write,
    input  logic [DW-1:0]   s1_writedata,
    input  logic [DW/8-1:0] s1_byteenable,
    input  logic            s1_debugaccess,
    output logic            s1_waitrequest,
    output logic [DW-1:0]   s1_readdata,
    output logic            s1_readdatavalid,
    output logic [AW-1:0]   mem_address,
    output logic [DW/8-1:0] mem_byteenable,
    output logic            mem_chipselect,
    output logic            mem_write,
    output logic [DW-1:0]   mem_writedata,
    output logic            mem_debugaccess,
    output logic            mem_clken,
    input  logic [DW-1:0]   mem_readdata,
    output logic [1:0]      err_sticky
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [1:0] req, gnt;
    logic       sel_rd, sel_wr, in_range, wr_ok;
    logic [AW-1:0] sel_addr;
    rsp_t       rsp_q, rsp_d;
    logic [1:0] err_q, err_d;

    assign req = {s1_read | s1_write, s0_read};

    // Reset also holds off grants so nothing reaches the macro while in reset.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (~reset),
        .hold    (reset_req | reset),
        .gnt     (gnt)
    );

    // A simultaneous read+write on port 1 is handled as a write.
    always_comb begin
        sel_addr = gnt[1] ? s1_address : s0_address;
        sel_wr   = gnt[1] & s1_write;
        sel_rd   = gnt[0] | (gnt[1] & ~s1_write);
        in_range = {1'b0, sel_addr} < DEPTH_W;
        wr_ok    = sel_wr & in_range & s1_debugaccess;
    end

    assign s0_waitrequest  = req[0] & ~gnt[0] & ~reset;
    assign s1_waitrequest  = req[1] & ~gnt[1] & ~reset;

    assign mem_address     = sel_addr;
    assign mem_byteenable  = gnt[1] ? s1_byteenable : '1;
    assign mem_writedata   = s1_writedata;
    assign mem_chipselect  = (sel_rd & in_range) | wr_ok;
    assign mem_write       = wr_ok;
    assign mem_debugaccess = gnt[1] & s1_debugaccess & mem_chipselect;
    assign mem_clken       = reset | ~reset_req;

    always_comb begin
        rsp_d.vld  = sel_rd;
        rsp_d.port = port_e'(gnt[1]);
        rsp_d.oor  = ~in_range;
        err_d      = err_q;
        if ((sel_rd | sel_wr) && !in_range) err_d[ERR_RANGE] = 1'b1;
        if (sel_wr && !s1_debugaccess)      err_d[ERR_NODBG] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q <= '0;
            err_q <= '0;
        end else begin
            rsp_q <= rsp_d;
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

    // Out-of-range reads answer with zero data; responses are masked during reset.
    always_comb begin
        s0_readdatavalid = rsp_q.vld & (rsp_q.port == PORT_IFETCH) & ~reset;
        s1_readdatavalid = rsp_q.vld & (rsp_q.port == PORT_DATA) & ~reset;
        s0_readdata      = (s0_readdatavalid && !rsp_q.oor) ? mem_readdata : '0;
        s1_readdata      = (s1_readdatavalid && !rsp_q.oor) ? mem_readdata : '0;
    end

endmodule

// File: tb/tb_qsys_system_rom_arbiter.sv
// Randomised bench for the boot-ROM arbiter with a request-level reference model.
module tb_qsys_system_rom_arbiter;

    localparam int DEPTH = 2560;

    logic        clk = 1'b0;
    logic        reset, reset_req;
    logic [11:0] s0_address, s1_address;
    logic        s0_read, s1_read, s1_write, s1_debugaccess;
    logic [31:0] s1_writedata;
    logic [3:0]  s1_byteenable;
    logic        s0_waitrequest, s0_readdatavalid, s1_waitrequest, s1_readdatavalid;
    logic [31:0] s0_readdata, s1_readdata;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic [1:0]  err_sticky;

    always #5 clk = ~clk;

    qsys_system_rom_arbiter dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .s0_address(s0_address), .s0_read(s0_read),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_debugaccess(s1_debugaccess),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_debugaccess(mem_debugaccess),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .err_sticky(err_sticky)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 5)     return 32'hDEADBEEF;
        if (i == 'h10)  return 32'hFFFFFFFF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // ROM macro: synchronous read, byte-enabled write, gated by clken.
    logic [31:0] rom [0:DEPTH-1];
    bit          rom_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rom_loaded) begin
            for (int i = 0; i < DEPTH; i++) rom[i] <= init_val(i);
            rom_loaded <= 1'b1;
        end else if (mem_clken && mem_chipselect && (int'(mem_address) < DEPTH)) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) rom[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= rom[mem_address];
            end
        end
    end

    // Reference model state
    logic [31:0] shd [0:DEPTH-1];
    int          m_ptr;
    bit          pv;
    int          pport;
    logic [31:0] pdata;
    logic [1:0]  merr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r0, input logic [11:0] a0,
                        input logic r1, input logic w1, input logic [11:0] a1,
                        input logic [31:0] wd, input logic [3:0] be, input logic dbg,
                        input logic rst, input logic rrq);
        int g;
        logic p0, p1, inr, isw, e_cs, e_mw;
        logic [11:0] addr;
        @(posedge clk);
        #1;
        reset = rst; reset_req = rrq;
        s0_read = r0; s0_address = a0;
        s1_read = r1; s1_write = w1; s1_address = a1;
        s1_writedata = wd; s1_byteenable = be; s1_debugaccess = dbg;
        @(negedge clk);
        p0 = r0;
        p1 = r1 | w1;
        g = -1;
        if (!rst && !rrq) begin
            if (p0 && p1) g = m_ptr;
            else if (p0)  g = 0;
            else if (p1)  g = 1;
        end
        addr = (g == 1) ? a1 : a0;
        inr  = int'(addr) < DEPTH;
        isw  = (g == 1) && w1;
        e_cs = (g >= 0) && inr && (!isw || dbg);
        e_mw = isw && inr && dbg;

        chk_eq("wait0", 32'(s0_waitrequest), 32'(!rst && p0 && g != 0));
        chk_eq("wait1", 32'(s1_waitrequest), 32'(!rst && p1 && g != 1));
        chk_eq("rdv0", 32'(s0_readdatavalid), 32'(!rst && pv && pport == 0));
        chk_eq("rdv1", 32'(s1_readdatavalid), 32'(!rst && pv && pport == 1));
        chk_eq("rdata0", s0_readdata, (!rst && pv && pport == 0) ? pdata : 32'h0);
        chk_eq("rdata1", s1_readdata, (!rst && pv && pport == 1) ? pdata : 32'h0);
        chk_eq("mem_cs", 32'(mem_chipselect), 32'(e_cs));
        chk_eq("mem_wr", 32'(mem_write), 32'(e_mw));
        chk_eq("clken", 32'(mem_clken), 32'(rst || !rrq));
        chk_eq("err", 32'(err_sticky), 32'(merr));
        if (e_cs) chk_eq("mem_addr", 32'(mem_address), 32'(addr));

        if (rst) begin
            m_ptr = 0; pv = 1'b0; merr = 2'b00;
        end else begin
            pv    = (g >= 0) && !isw;
            pport = g;
            pdata = inr ? shd[addr] : 32'h0;
            if (g >= 0) begin
                if (!inr) merr[0] = 1'b1;
                if (isw && !dbg) merr[1] = 1'b1;
                if (e_mw)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) shd[addr][8*b +: 8] = wd[8*b +: 8];
                m_ptr = 1 - g;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) shd[i] = init_val(i);
        m_ptr = 0; pv = 1'b0; pport = 0; pdata = 0; merr = 2'b00;
        reset = 1'b1; reset_req = 1'b0;
        s0_read = 0; s0_address = 0; s1_read = 0; s1_write = 0; s1_address = 0;
        s1_writedata = 0; s1_byteenable = 0; s1_debugaccess = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // single-port read of the preloaded word
        step(1, 12'h005, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk_eq("plan_rd", s0_readdata, 32'hDEADBEEF);

        // continuous contention
        for (int i = 0; i < 6; i++)
            step(1, 12'($urandom_range(DEPTH-1)), 1, 0, 12'($urandom_range(DEPTH-1)), 0, 0, 0, 0, 0);
        idle();

        // out-of-range read
        step(1, 12'd2560, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk_eq("plan_oor_err", 32'(err_sticky), 32'h1);

        // debug write, then readback
        step(0, 0, 0, 1, 12'h010, 32'h12345678, 4'b0011, 1, 0, 0);
        step(0, 0, 1, 0, 12'h010, 0, 0, 0, 0, 0);
        idle();
        chk_eq("plan_dbg_rb", s1_readdata, 32'hFFFF5678);

        // write without debugaccess is dropped
        step(0, 0, 0, 1, 12'h010, 32'h0, 4'b1111, 0, 0, 0);
        step(0, 0, 1, 0, 12'h010, 0, 0, 0, 0, 0);
        idle();
        chk_eq("plan_nodbg_rb", s1_readdata, 32'hFFFF5678);
        chk_eq("plan_nodbg_err", 32'(err_sticky), 32'h3);

        // reset_req while both ports request, then release
        step(1, 12'h020, 1, 0, 12'h021, 0, 0, 0, 0, 1);
        step(1, 12'h020, 1, 0, 12'h021, 0, 0, 0, 0, 1);
        step(1, 12'h020, 1, 0, 12'h021, 0, 0, 0, 0, 0);
        step(1, 12'h020, 1, 0, 12'h021, 0, 0, 0, 0, 0);
        idle();

        // reset asserted in the cycle after a grant
        step(1, 12'h005, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [11:0] ra0, ra1;
            ra0 = ($urandom_range(15) == 0) ? 12'($urandom_range(4095, DEPTH)) : 12'($urandom_range(DEPTH-1));
            ra1 = ($urandom_range(15) == 0) ? 12'($urandom_range(4095, DEPTH)) : 12'($urandom_range(DEPTH-1));
            step(1'($urandom_range(1)), ra0,
                 1'($urandom_range(1)), 1'($urandom_range(3) == 0), ra1,
                 $urandom, 4'($urandom_range(15)), 1'($urandom_range(3) != 0),
                 1'($urandom_range(63) == 0), 1'($urandom_range(15) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qsys_system_rom_arbiter.md
# qsys_system_rom_arbiter

Two-port Avalon-MM arbiter that shares the single-port on-chip boot ROM (2560 × 32-bit, 12-bit word address, synchronous read, 1-cycle latency) between the processor instruction master (port 0, read-only) and the data/debug master (port 1, read/write). It sits between the interconnect and the ROM macro. It serialises accesses with round-robin priority and generates per-port `readdatavalid`. It also blocks writes that lack debug access, range-checks addresses, and honours `reset_req` by freezing the memory clock enable.

## Interface
- `DEPTH`, 2560: number of valid memory words; addresses ≥ DEPTH are out of range.
- `AW`, 12: word address width.
- `DW`, 32: data width; byte-enable width is DW/8.
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `reset_req` in 1: reset-request; while high, no grants and `mem_clken` = 0.
- `s0_address` in AW, `s0_read` in 1: port 0 read request.
- `s0_waitrequest` out 1, `s0_readdata` out DW, `s0_readdatavalid` out 1: port 0 response.
- `s1_address` in AW, `s1_read` in 1, `s1_write` in 1, `s1_writedata` in DW, `s1_byteenable` in DW/8, `s1_debugaccess` in 1: port 1 request.
- `s1_waitrequest` out 1, `s1_readdata` out DW, `s1_readdatavalid` out 1: port 1 response.
- `mem_address` out AW, `mem_byteenable` out DW/8, `mem_chipselect` out 1, `mem_write` out 1, `mem_writedata` out DW, `mem_debugaccess` out 1, `mem_clken` out 1: drive to the ROM macro.
- `mem_readdata` in DW: ROM output, valid one cycle after address.
- `err_sticky` out 2: bit0 = out-of-range access, bit1 = write without debugaccess. Cleared only by reset.

## Operation
- A request is pending on port 0 when `s0_read` = 1. It is pending on port 1 when `s1_read | s1_write` = 1. Asserting `s1_read` and `s1_write` together is illegal; treat it as a write.
- At most one grant per cycle. A grant is combinational in the same cycle: the granted port sees `waitrequest` = 0, and the other port sees 1.
- A port with no pending request sees `waitrequest` = 0. This matches Avalon idle semantics.
- **Single requester:** the lone requester is granted.
- **Both requesting:** the port selected by the `rr_ptr` register is granted.
- **`rr_ptr`:**
  - Reset value 0 (port 0 favoured).
  - After any grant, `rr_ptr` ← the index of the other port.
- **Reads:** on a granted read, drive `mem_address` and `mem_chipselect` = 1. Register a 2-bit `rsp_owner` (valid + port) for the next cycle.
- **Writes:** a granted port 1 write with `s1_debugaccess` = 1 drives `mem_write` = `mem_chipselect` = `mem_debugaccess` = 1, passing byteenable and writedata through. No readdatavalid is generated.
- **Write without debugaccess:** it is accepted (waitrequest 0) and dropped: `mem_write` = 0 and `mem_chipselect` = 0. It sets `err_sticky[1]`.
- **Out-of-range (address ≥ DEPTH):**
  - The memory is not selected.
  - A read still returns `readdatavalid` next cycle with data 0x00000000.
  - A write is dropped.
  - Either case sets `err_sticky[0]`.
- **Response path:** `sN_readdatavalid` = `rsp_owner` valid and owner == N.
  - `sN_readdata` = `mem_readdata`, or 0 for an out-of-range read (flag registered with `rsp_owner`).
  - `sN_readdata` = 0 when `sN_readdatavalid` = 0.
- **`reset_req`:**
  - Both pending ports get `waitrequest` = 1, and `mem_clken` = 0. Otherwise `mem_clken` = 1.
  - A read granted in the cycle before `reset_req` rises still completes (`rsp_owner` advances regardless). Its data is whatever `mem_readdata` holds.

## Timing
- Request accepted in cycle N (read & !waitrequest) → readdatavalid in cycle N+1. The fixed latency is 1, and there is no other outstanding depth.
- Back-to-back reads from alternating ports are granted every cycle, giving full memory throughput.
- Under continuous contention the grant alternates 0, 1, 0, 1…, so the worst-case wait for either port is 1 cycle.
- **Reset values:** all `waitrequest` = 0 (idle), `readdatavalid` = 0, `readdata` = 0, `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 1, `err_sticky` = 0, `rr_ptr` = 0, `rsp_owner` invalid.
- **Reset asserted mid-read:** the pending readdatavalid is suppressed in the following cycle.
- The `mem_*` outputs are combinational from the grant. `rsp_owner`, `rr_ptr` and `err_sticky` are the only state.

## Structure
- **Shared package `qsys_system_rom_pkg`:**
  - Constants `ROM_DEPTH` = 2560, `ROM_AW` = 12, `ROM_DW` = 32.
  - Port-index enum (`PORT_IFETCH` = 0, `PORT_DATA` = 1).
  - `err_sticky` bit positions.
- **Sub-module `rr_arbiter2`:**
  - Two-request round-robin grant with a pointer register.
  - Inputs: req[1:0], advance, hold (`reset_req`).
  - Output: one-hot gnt.
- The top level holds the address check, the write gating and the response register.

## Test plan
- **Single-port read:** port 0 reads address 0x005 (preloaded 0xDEADBEEF) → `s0_waitrequest` = 0 in the same cycle; next cycle `s0_readdatavalid` = 1 with 0xDEADBEEF, and `s1_readdatavalid` = 0.
- **Contention:** both ports read continuously for 6 cycles from reset → grants 0, 1, 0, 1, 0, 1. Each readdatavalid lands on the correct port one cycle after its grant.
- **Debug write then read:**
  - Port 1 writes 0x12345678 to address 0x010 with byteenable 0b0011 and debugaccess = 1, after the location was preloaded with 0xFFFFFFFF.
  - Readback returns 0xFFFF5678.
  - Repeating the write with debugaccess = 0 leaves the data unchanged and sets `err_sticky[1]`.
- **Out of range:** port 0 reads address 2560 → `mem_chipselect` = 0, readdatavalid next cycle with data 0, and `err_sticky` = 0b01.
- **`reset_req`:** raise it while both ports request → both waitrequest = 1 and `mem_clken` = 0. On release, the grant resumes at `rr_ptr` without losing a request.
- **Reset mid-read:** assert `reset` in the cycle after a grant → no readdatavalid, and all outputs at their reset values.
